// File: rtl/cond_unit_if.sv
// Handshake and data bundle for cond_unit: upstream instruction fields, writeback
// handshake, gated side effects and the committed flag register.
interface cond_unit_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_cond;
  logic       in_set_flags;
  logic       in_reg_we;
  logic       in_mem_we;
  logic       in_branch;
  logic       alu_zero;
  logic       alu_lt;
  logic       alu_gt;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic       out_reg_we;
  logic       out_mem_we;
  logic       out_pc_src;
  logic [2:0] flags_q;

  modport slave (
    input  in_valid, in_cond, in_set_flags, in_reg_we, in_mem_we, in_branch,
    input  alu_zero, alu_lt, alu_gt, flush, out_ready,
    output in_ready, out_valid, out_reg_we, out_mem_we, out_pc_src, flags_q
  );

  modport master (
    output in_valid, in_cond, in_set_flags, in_reg_we, in_mem_we, in_branch,
    output alu_zero, alu_lt, alu_gt, flush, out_ready,
    input  in_ready, out_valid, out_reg_we, out_mem_we, out_pc_src, flags_q
  );
endinterface

// File: rtl/cond_unit.sv
// Condition evaluation / flag commit stage: one registered slot between ALU and writeback.
// Define COND_FWD_EN to forward pending flags from the output stage instead of stalling.
module cond_unit (
  input  logic        clk,
  input  logic        rst_n,
  cond_unit_if.slave  bus
);

  function automatic logic cond_pass(input logic [3:0] cond, input logic [2:0] f);
    logic z, lt, gt;
    z  = f[2];
    lt = f[1];
    gt = f[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = !lt;
      4'b0011: cond_pass = lt;
      4'b1000: cond_pass = gt;
      4'b1001: cond_pass = !gt;
      4'b1010: cond_pass = !lt;
      4'b1011: cond_pass = lt;
      4'b1100: cond_pass = gt;
      4'b1101: cond_pass = !gt;
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  logic       out_valid_reg;
  logic       out_reg_we_reg;
  logic       out_mem_we_reg;
  logic       out_pc_src_reg;
  logic       pend_set_reg;
  logic [2:0] cap_flags_reg;
  logic [2:0] flags_reg;

  logic       hazard;
  logic [2:0] eff_flags;
  logic       in_ready_next;
  logic       accept;
  logic       fire;
  logic       pass;
  logic [2:0] req;
  logic [2:0] gated;

`ifdef COND_FWD_EN
  // Pending flags in the output stage are used directly by the next instruction.
  assign hazard    = 1'b0;
  assign eff_flags = (out_valid_reg && pend_set_reg) ? cap_flags_reg : flags_reg;
`else
  // Hold the follower until the flag-setting instruction has committed.
  assign hazard    = out_valid_reg & pend_set_reg;
  assign eff_flags = flags_reg;
`endif

  assign in_ready_next = (!out_valid_reg || bus.out_ready) && !bus.flush && !hazard;
  assign accept        = bus.in_valid && in_ready_next;
  assign fire          = out_valid_reg && bus.out_ready && !bus.flush;
  assign pass          = cond_pass(bus.in_cond, eff_flags);

  // req/gated bit order: {branch, mem_we, reg_we}
  assign req = {bus.in_branch, bus.in_mem_we, bus.in_reg_we};
  for (genvar gi = 0; gi < 3; gi++) begin : g_gate
    assign gated[gi] = req[gi] & pass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_reg_we_reg <= 1'b0;
      out_mem_we_reg <= 1'b0;
      out_pc_src_reg <= 1'b0;
      pend_set_reg   <= 1'b0;
      cap_flags_reg  <= 3'b000;
      flags_reg      <= 3'b000;
    end else begin
      if (bus.flush) begin
        out_valid_reg  <= 1'b0;
        out_reg_we_reg <= 1'b0;
        out_mem_we_reg <= 1'b0;
        out_pc_src_reg <= 1'b0;
        pend_set_reg   <= 1'b0;
      end else if (accept) begin
        out_valid_reg  <= 1'b1;
        out_reg_we_reg <= gated[0];
        out_mem_we_reg <= gated[1];
        out_pc_src_reg <= gated[2];
        pend_set_reg   <= bus.in_set_flags & pass;
        cap_flags_reg  <= {bus.alu_zero, bus.alu_lt, bus.alu_gt};
      end else if (fire) begin
        out_valid_reg  <= 1'b0;
        out_reg_we_reg <= 1'b0;
        out_mem_we_reg <= 1'b0;
        out_pc_src_reg <= 1'b0;
        pend_set_reg   <= 1'b0;
      end

      if (fire && pend_set_reg) begin
        flags_reg <= cap_flags_reg;
      end
    end
  end

  assign bus.in_ready   = in_ready_next;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_reg_we = out_reg_we_reg;
  assign bus.out_mem_we = out_mem_we_reg;
  assign bus.out_pc_src = out_pc_src_reg;
  assign bus.flags_q    = flags_reg;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: hand-written corner sequences, then a vector table streamed
// through a scoreboard under random writeback backpressure.
module tb_cond_unit;

  typedef struct {
    logic [3:0] cond;
    logic       set;
    logic       rw;
    logic       mw;
    logic       br;
    logic [2:0] alu;
    logic       exp_rw;
    logic       exp_mw;
    logic       exp_pc;
    logic [2:0] exp_flags;
  } vec_t;

  typedef struct {
    int         idx;
    logic       rw;
    logic       mw;
    logic       pc;
    logic [2:0] flags;
  } exp_t;

  logic clk;
  logic rst_n;
  cond_unit_if bus();

  cond_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  bit   sb_en  = 1'b0;
  bit   rnd_en = 1'b0;
  bit   flag_chk = 1'b0;
  logic [2:0] chk_flags;
  int   chk_idx;
  vec_t vec[19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic [3:0] cond, input logic set, input logic rw,
                       input logic mw, input logic br, input logic [2:0] alu);
    bus.in_cond      = cond;
    bus.in_set_flags = set;
    bus.in_reg_we    = rw;
    bus.in_mem_we    = mw;
    bus.in_branch    = br;
    {bus.alu_zero, bus.alu_lt, bus.alu_gt} = alu;
    bus.in_valid     = 1'b1;
  endtask

  // Waits for acceptance; returns at posedge+1 after the accepting edge.
  task automatic wait_accept(input bit push, input exp_t e, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (push) sb_q.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard monitor: pops on every fire and checks flags one cycle later.
  always @(negedge clk) begin
    if (flag_chk) begin
      check($sformatf("vec%0d_flags", chk_idx), {29'd0, bus.flags_q}, {29'd0, chk_flags});
      flag_chk = 1'b0;
    end
    if (sb_en && rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("vec%0d_reg_we", e.idx), {31'd0, bus.out_reg_we}, {31'd0, e.rw});
        check($sformatf("vec%0d_mem_we", e.idx), {31'd0, bus.out_mem_we}, {31'd0, e.mw});
        check($sformatf("vec%0d_pc_src", e.idx), {31'd0, bus.out_pc_src}, {31'd0, e.pc});
        chk_idx   = e.idx;
        chk_flags = e.flags;
        flag_chk  = 1'b1;
      end
    end
  end

  // Random writeback backpressure during the table phase.
  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    exp_t dummy;
    int   stalls;
    int   exp_bubble;
    dummy = '{0, 1'b0, 1'b0, 1'b0, 3'b000};

    // Flags start at 000; each row's expectations follow from the rows above it.
    vec[0]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 3'b100};
    vec[1]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 3'b100};
    vec[2]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b100};
    vec[3]  = '{4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 3'b010};
    vec[4]  = '{4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b010};
    vec[5]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010};
    vec[6]  = '{4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010};
    vec[7]  = '{4'b1011, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 3'b001};
    vec[8]  = '{4'b1100, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 3'b001};
    vec[9]  = '{4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b001};
    vec[10] = '{4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001};
    vec[11] = '{4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001};
    vec[12] = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 3'b001};
    vec[13] = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001};
    vec[14] = '{4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 1'b1, 3'b100};
    vec[15] = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100};
    vec[16] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000};
    vec[17] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000};
    vec[18] = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000};

`ifdef COND_FWD_EN
    exp_bubble = 0;
`else
    exp_bubble = 1;
`endif

    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    bus.in_valid = 1'b0;
    #3;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_flags", {29'd0, bus.flags_q}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // CMP (Z=1) immediately followed by BEQ.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
    wait_accept(1'b0, dummy, stalls);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    wait_accept(1'b0, dummy, stalls);
    $display("cmp_beq: bubble cycles %0d", stalls);
    check("cmp_beq_bubble", stalls, exp_bubble);
    @(negedge clk);
    check("beq_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("beq_pc_src", {31'd0, bus.out_pc_src}, 32'd1);
    check("cmp_flags", {29'd0, bus.flags_q}, 32'd4);
    @(posedge clk); #1;

    // Backpressure: flag-setting instruction held three cycles.
    bus.out_ready = 1'b0;
    drive(4'b1110, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001);
    wait_accept(1'b0, dummy, stalls);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      $display("backpressure cycle %0d: in_ready=%0b rw=%0b mw=%0b flags=%03b",
               k, bus.in_ready, bus.out_reg_we, bus.out_mem_we, bus.flags_q);
      check($sformatf("bp%0d_in_ready", k), {31'd0, bus.in_ready}, 32'd0);
      check($sformatf("bp%0d_reg_we", k), {31'd0, bus.out_reg_we}, 32'd1);
      check($sformatf("bp%0d_mem_we", k), {31'd0, bus.out_mem_we}, 32'd1);
      check($sformatf("bp%0d_pc_src", k), {31'd0, bus.out_pc_src}, 32'd0);
      check($sformatf("bp%0d_flags", k), {29'd0, bus.flags_q}, 32'd4);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_flags", {29'd0, bus.flags_q}, 32'd1);

    // Flush of a held flag-setting instruction.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010);
    wait_accept(1'b0, dummy, stalls);
    @(negedge clk);
    check("flush_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    $display("flush: out_valid=%0b flags=%03b", bus.out_valid, bus.flags_q);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_reg_we", {31'd0, bus.out_reg_we}, 32'd0);
    check("flush_flags", {29'd0, bus.flags_q}, 32'd1);

    // Asynchronous reset with an instruction held in the output stage.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
    wait_accept(1'b0, dummy, stalls);
    @(negedge clk);
    check("mid_rst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("mid-transfer reset: out_valid=%0b flags=%03b", bus.out_valid, bus.flags_q);
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_reg_we", {31'd0, bus.out_reg_we}, 32'd0);
    check("mid_rst_mem_we", {31'd0, bus.out_mem_we}, 32'd0);
    check("mid_rst_pc_src", {31'd0, bus.out_pc_src}, 32'd0);
    check("mid_rst_flags", {29'd0, bus.flags_q}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Vector table through the scoreboard with random backpressure.
    @(posedge clk); #1;
    sb_en  = 1'b1;
    rnd_en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      exp_t e;
      e = '{i, vec[i].exp_rw, vec[i].exp_mw, vec[i].exp_pc, vec[i].exp_flags};
      drive(vec[i].cond, vec[i].set, vec[i].rw, vec[i].mw, vec[i].br, vec[i].alu);
      wait_accept(1'b1, e, stalls);
      $display("vec%0d: cond=%04b accepted after %0d stall cycles", i, vec[i].cond, stalls);
    end
    for (int c = 0; c < 200 && sb_q.size() != 0; c++) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    rnd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-evaluation and flag-commit stage that sits on the far side of the ALU. It holds the architectural flag register (Z, LT, GT), decodes each instruction's 4-bit condition field against those flags, and gates the instruction's side effects: register write, memory write, branch, and flag update. It is one registered pipeline stage with valid/ready handshakes between decode/ALU and writeback.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_cond  in  4  condition field
- in_set_flags  in  1  instruction writes flags (CMP / S-suffix)
- in_reg_we, in_mem_we, in_branch  in  1 each  raw side-effect requests
- alu_zero, alu_lt, alu_gt  in  1 each  ALU flags for this instruction
- flush  in  1  discard output-stage contents
- out_valid  out  1  output stage holds instruction
- out_ready  in  1  writeback accepts
- out_reg_we, out_mem_we, out_pc_src  out  1 each  gated side effects
- flags_q  out  3  committed flags {Z, LT, GT}

## Operation
- Condition decode against effective flags f: 0000 EQ=Z; 0001 NE=!Z; 0010 HS=!LT; 0011 LO=LT; 1000 HI=GT; 1001 LS=!GT; 1010 GE=!LT; 1011 LT=LT; 1100 GT=GT; 1101 LE=!GT; 1110 AL=1; 1111 and all other codes = 0 (never).
- pass = decoded condition. On accept (in_valid & in_ready), the output stage captures reg_we&pass, mem_we&pass, branch&pass, pend_set = set_flags&pass, and the three ALU flags.
- The flag register commits the captured ALU flags when the output fires (out_valid & out_ready & !flush) and pend_set = 1. A failed condition never changes the flags.
- Effective flags f = flags_q, except when forwarding applies (see Configuration).
- flush: on the next edge, out_valid clears and out_* clear, with no commit even if out_ready is high. in_ready = 0 while flush is high.
- Reset (asynchronous, rst_n low): flags_q = 3'b000, out_valid = 0, out_reg_we = out_mem_we = out_pc_src = 0, pend_set = 0. in_ready = 1 once rst_n is high. Reset mid-transfer drops the held instruction.

## Timing
- Latency 1: an instruction accepted at edge k is visible on out_* from edge k until it fires.
- in_ready = (!out_valid | out_ready) & !flush & !hazard. This allows full throughput with simultaneous fire and accept.
- out_* stay stable while out_valid & !out_ready.
- Flags committed at a fire edge are visible on flags_q in the following cycle.
- hazard is defined under Configuration.

## Configuration
- COND_FWD_EN defined:
  - hazard = 0.
  - When out_valid & pend_set, f = the output stage's captured flags; otherwise f = flags_q.
  - Back-to-back CMP -> conditional instruction runs with no bubble.
- COND_FWD_EN undefined:
  - hazard = out_valid & pend_set.
  - f = flags_q always.
  - A flag-setting instruction in the output stage costs exactly one bubble cycle for the following instruction.

## Test plan
- Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, flags_q=000, all out_* 0 immediately (asynchronous).
- CMP then BEQ:
  - Stimulus: CMP (set_flags=1, cond=1110, alu_zero=1), then in_branch=1 with cond=0000 on the next cycle.
  - Response: out_pc_src=1; flags_q=100 after the CMP fires.
  - Without COND_FWD_EN, in_ready=0 for exactly one cycle between the two.
- Failed condition: flags_q=100, instruction with cond=0001, reg_we=1, set_flags=1, alu flags 010 -> out_reg_we=0, flags_q remains 100.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* held constant, no flag commit until out_ready=1.
- Flush: flag-setting instruction held in the output stage, flush=1 with out_ready=1 -> out_valid=0 next cycle, flags_q unchanged, in_ready=0 during flush.
- Never/AL codes: cond=1111 with all requests set -> all out_* 0. cond=1110 -> all requests pass through.
